// File: rtl/video_timing_if.sv
// Pixel-domain bundle between the raster timing generator
// and the renderer / encoder that consume its position and flags.
interface video_timing_if #(
   parameter int CW  = 10,
   parameter int FCW = 8
);
   logic           vtg_ce;
   logic           enable;
   logic [CW-1:0]  pixel_x;
   logic [CW-1:0]  pixel_y;
   logic           hsync;
   logic           vsync;
   logic           hblank;
   logic           vblank;
   logic           video_on;
   logic           line_start;
   logic           frame_start;
   logic           running;
   logic [FCW-1:0] frame_count;

   modport master (
      input  vtg_ce,
      input  enable,
      output pixel_x,
      output pixel_y,
      output hsync,
      output vsync,
      output hblank,
      output vblank,
      output video_on,
      output line_start,
      output frame_start,
      output running,
      output frame_count
   );

   modport slave (
      output vtg_ce,
      output enable,
      input  pixel_x,
      input  pixel_y,
      input  hsync,
      input  vsync,
      input  hblank,
      input  vblank,
      input  video_on,
      input  line_start,
      input  frame_start,
      input  running,
      input  frame_count
   );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with a run/drain FSM
// that only starts and stops the raster on frame boundaries.
module video_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CW        = 10,
   parameter int FCW       = 8
) (
   input  logic           pixel_clk,
   input  logic           reset,
   video_timing_if.master vif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int HS_END  = HS_BEG + H_SYNC;
   localparam int VS_BEG  = V_ACTIVE + V_FP;
   localparam int VS_END  = VS_BEG + V_SYNC;

   if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
      $error("video_timing_gen: totals exceed 2**CW");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  x_q, y_q, x_d, y_d;
   logic [FCW-1:0] fc_q, fc_d;
   logic           hs_q, vs_q, hb_q, vb_q;
   logic           vo_q, ls_q, fs_q, run_q;
   logic           hs_d, vs_d, hb_d, vb_d;
   logic           vo_d, ls_d, fs_d, run_d;
   logic           x_end, y_end;

   assign x_end = 32'(x_q) == H_TOTAL - 1;
   assign y_end = 32'(y_q) == V_TOTAL - 1;

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         fc_q    <= '0;
         hs_q    <= ~HSYNC_POL;
         vs_q    <= ~VSYNC_POL;
         hb_q    <= 1'b1;
         vb_q    <= 1'b1;
         vo_q    <= 1'b0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fc_q    <= fc_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         hb_q    <= hb_d;
         vb_q    <= vb_d;
         vo_q    <= vo_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
         run_q   <= run_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (vif.enable) state_d = RUN;
         RUN:
            if (!vif.enable) state_d = DRAIN;
         DRAIN:
            if (vif.enable)
               state_d = RUN;
            else if (vif.vtg_ce && x_end && y_end)
               state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   // Flags are computed from the next position so they line up
   // with the counters in the same register stage.
   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      fc_d = fc_q;
      ls_d = 1'b0;
      fs_d = 1'b0;
      if (state_d == IDLE) begin
         x_d = '0;
         y_d = '0;
      end else if (state_q == IDLE) begin
         x_d  = '0;
         y_d  = '0;
         ls_d = 1'b1;
         fs_d = 1'b1;
         fc_d = fc_q + FCW'(1);
      end else if (vif.vtg_ce) begin
         if (x_end) begin
            x_d  = '0;
            ls_d = 1'b1;
            if (y_end) begin
               y_d  = '0;
               fs_d = 1'b1;
               fc_d = fc_q + FCW'(1);
            end else begin
               y_d = y_q + CW'(1);
            end
         end else begin
            x_d = x_q + CW'(1);
         end
      end
      run_d = state_d != IDLE;
      hb_d  = !run_d || 32'(x_d) >= H_ACTIVE;
      vb_d  = !run_d || 32'(y_d) >= V_ACTIVE;
      vo_d  = run_d && !hb_d && !vb_d;
      hs_d  = ~HSYNC_POL;
      vs_d  = ~VSYNC_POL;
      if (run_d && 32'(x_d) >= HS_BEG && 32'(x_d) < HS_END)
         hs_d = HSYNC_POL;
      if (run_d && 32'(y_d) >= VS_BEG && 32'(y_d) < VS_END)
         vs_d = VSYNC_POL;
   end

   assign vif.pixel_x     = x_q;
   assign vif.pixel_y     = y_q;
   assign vif.hsync       = hs_q;
   assign vif.vsync       = vs_q;
   assign vif.hblank      = hb_q;
   assign vif.vblank      = vb_q;
   assign vif.video_on    = vo_q;
   assign vif.line_start  = ls_q;
   assign vif.frame_start = fs_q;
   assign vif.running     = run_q;
   assign vif.frame_count = fc_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen against a linear
// pixel-index raster model; runs both sync polarities side by side.
module tb_video_timing_gen;
   localparam int HT = 8;
   localparam int VT = 6;
   localparam int FR = HT * VT;
   localparam int FM = 16;

   logic pixel_clk = 1'b0;
   logic reset     = 1'b1;

   int n_vec   = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int fs_last = 0;
   int fs_gap  = 0;

   bit m_run;
   bit m_drain;
   bit m_ls;
   bit m_fs;
   int m_p;
   int m_fc;

   video_timing_if #(.CW(3), .FCW(4)) vif0 ();
   video_timing_if #(.CW(3), .FCW(4)) vif1 ();

   video_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
      .CW(3), .FCW(4)
   ) dut0 (
      .pixel_clk(pixel_clk),
      .reset(reset),
      .vif(vif0)
   );

   video_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
      .CW(3), .FCW(4)
   ) dut1 (
      .pixel_clk(pixel_clk),
      .reset(reset),
      .vif(vif1)
   );

   always #5 pixel_clk = ~pixel_clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic model(input bit r, input bit en, input bit ce);
      m_ls = 1'b0;
      m_fs = 1'b0;
      if (r) begin
         m_run   = 1'b0;
         m_drain = 1'b0;
         m_p     = 0;
         m_fc    = 0;
      end else if (!m_run) begin
         if (en) begin
            m_run   = 1'b1;
            m_drain = 1'b0;
            m_p     = 0;
            m_ls    = 1'b1;
            m_fs    = 1'b1;
            m_fc    = (m_fc + 1) % FM;
         end
      end else if (m_drain && !en && ce && m_p == FR - 1) begin
         m_run = 1'b0;
         m_p   = 0;
      end else begin
         if (ce) begin
            m_p  = (m_p + 1) % FR;
            m_ls = (m_p % HT) == 0;
            if (m_p == 0) begin
               m_fs = 1'b1;
               m_fc = (m_fc + 1) % FM;
            end
         end
         m_drain = !en;
      end
   endtask

   task automatic cycle(input bit r, input bit en, input bit ce);
      int x, y;
      bit hs, vs, hb, vb, vo;
      reset       = r;
      vif0.enable = en;
      vif0.vtg_ce = ce;
      vif1.enable = en;
      vif1.vtg_ce = ce;
      @(posedge pixel_clk);
      #1;
      cyc++;
      model(r, en, ce);
      x  = m_p % HT;
      y  = m_p / HT;
      hs = m_run && x >= 5 && x < 7;
      vs = m_run && y == 4;
      hb = !m_run || x >= 4;
      vb = !m_run || y >= 3;
      vo = m_run && !hb && !vb;
      chk("pixel_x",     vif0.pixel_x,     x);
      chk("pixel_y",     vif0.pixel_y,     y);
      chk("hsync",       vif0.hsync,       int'(!hs));
      chk("vsync",       vif0.vsync,       int'(!vs));
      chk("hblank",      vif0.hblank,      int'(hb));
      chk("vblank",      vif0.vblank,      int'(vb));
      chk("video_on",    vif0.video_on,    int'(vo));
      chk("line_start",  vif0.line_start,  int'(m_ls));
      chk("frame_start", vif0.frame_start, int'(m_fs));
      chk("running",     vif0.running,     int'(m_run));
      chk("frame_count", vif0.frame_count, m_fc);
      chk("p1_hsync",    vif1.hsync,       int'(hs));
      chk("p1_vsync",    vif1.vsync,       int'(vs));
      chk("p1_pixel_x",  vif1.pixel_x,     x);
      chk("p1_pixel_y",  vif1.pixel_y,     y);
      chk("p1_hblank",   vif1.hblank,      int'(hb));
      chk("p1_vblank",   vif1.vblank,      int'(vb));
      chk("p1_video_on", vif1.video_on,    int'(vo));
      chk("p1_ls",       vif1.line_start,  int'(m_ls));
      chk("p1_fs",       vif1.frame_start, int'(m_fs));
      chk("p1_running",  vif1.running,     int'(m_run));
      chk("p1_fc",       vif1.frame_count, m_fc);
      if (vif0.frame_start === 1'b1) begin
         fs_gap  = cyc - fs_last;
         fs_last = cyc;
      end
   endtask

   task automatic run_until(input int tgt, input bit en);
      for (int n = 0; n < 400; n++) begin
         if (m_run && m_p == tgt) break;
         cycle(1'b0, en, 1'b1);
      end
      chk("reach_x", vif0.pixel_x, tgt % HT);
      chk("reach_y", vif0.pixel_y, tgt / HT);
   endtask

   initial begin
      bit en_r;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      chk("fc_first", vif0.frame_count, 1);
      chk("fs_first", vif0.frame_start, 1);
      for (int i = 0; i < 150; i++) cycle(1'b0, 1'b1, 1'b1);
      chk("fs_period_ce1", fs_gap, FR);

      for (int i = 0; i < 600; i++)
         cycle(1'b0, 1'b1, (i % 4) == 0);
      chk("fs_period_ce4", fs_gap, 4 * FR);

      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      run_until(2 * HT + 3, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0, 1'b1);
      chk("drain_running", vif0.running, 0);
      chk("drain_fc", vif0.frame_count, 1);
      chk("drain_hblank", vif0.hblank, 1);

      cycle(1'b0, 1'b1, 1'b1);
      run_until(2 * HT + 3, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      run_until(4 * HT + 6, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b1);
      chk("reen_running", vif0.running, 1);
      chk("reen_fs_gap", fs_gap, FR);

      run_until(HT + 2, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      chk("rst_fc", vif0.frame_count, 0);
      chk("rst_running", vif0.running, 0);
      cycle(1'b0, 1'b0, 1'b1);

      cycle(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 17 * FR + 4; i++)
         cycle(1'b0, 1'b1, 1'b1);

      en_r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 63) == 0) en_r = ~en_r;
         cycle($urandom_range(0, 999) == 0, en_r,
               $urandom_range(0, 2) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end
endmodule
